// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latches irq lines, masks and prioritises them,
// then runs the request/ack/service handshake with the fetch stage.
module int_ctrl #(
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(2**ID_W)-1:0]   irq,
  input  logic                   mask_wr,
  input  logic [(2**ID_W)-1:0]   mask_in,
  input  logic                   int_ack,
  input  logic                   int_done,
  output logic                   ipu_int,
  output logic [ID_W-1:0]        int_id,
  output logic                   int_active,
  output logic [(2**ID_W)-1:0]   pending,
  output logic [(2**ID_W)-1:0]   mask,
  output logic                   ack_err
);

  localparam int unsigned NSRC = 2**ID_W;

  typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] irq_edge;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clear;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [3:0]      ack_cnt;

  always_comb begin
    irq_edge = irq & ~irq_q;
    elig     = pending & ~mask;
    winner   = '0;
    found    = 1'b0;
    // Scan from the top so the lowest eligible index is the last to win.
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (elig[i-1]) begin
        winner = ID_W'(i - 1);
        found  = 1'b1;
      end
    end
    clear = '0;
    if (state == IDLE && found) clear[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (rst) begin
      state      <= IDLE;
      ipu_int    <= 1'b0;
      int_id     <= '0;
      int_active <= 1'b0;
      pending    <= '0;
      mask       <= '1;
      ack_err    <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      pending <= (pending & ~clear) | irq_edge;
      if (mask_wr) mask <= mask_in;
      ipu_int <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state      <= REQ;
            int_id     <= winner;
            ipu_int    <= 1'b1;
            int_active <= 1'b1;
          end
        end
        REQ: begin
          state   <= ACK;
          ack_cnt <= '0;
        end
        ACK: begin
          if (int_ack) begin
            state <= SERVICE;
          end else if (ack_cnt == 4'(ACK_TIMEOUT - 1)) begin
            // Re-issue the same ID; the pending bit was already consumed.
            ack_err <= 1'b1;
            state   <= REQ;
            ipu_int <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 4'd1;
          end
        end
        SERVICE: begin
          if (int_done) begin
            state      <= IDLE;
            int_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_int_ctrl;

  localparam int ID_W        = 2;
  localparam int NSRC        = 2**ID_W;
  localparam int ACK_TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic            mask_wr;
  logic [NSRC-1:0] mask_in;
  logic            int_ack;
  logic            int_done;
  logic            ipu_int;
  logic [ID_W-1:0] int_id;
  logic            int_active;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            ack_err;

  int_ctrl #(.ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_wr(mask_wr), .mask_in(mask_in),
    .int_ack(int_ack), .int_done(int_done), .ipu_int(ipu_int),
    .int_id(int_id), .int_active(int_active), .pending(pending),
    .mask(mask), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus values for the next cycle.
  bit            rst_v, mask_wr_v, done_v, ack_en;
  bit [NSRC-1:0] irq_v, mask_in_v;

  // Reference model: what the outputs must be during the current cycle.
  bit            m_valid;
  bit [NSRC-1:0] m_pend, m_mask, m_irq_prev;
  bit            m_ipu, m_err, m_waiting, m_serving;
  int            m_id, m_wait;
  bit            last_ipu;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit ack);
    bit [NSRC-1:0] edges;
    int claim;
    bit n_ipu;
    last_ipu = m_valid && m_ipu;
    if (rst_v) begin
      m_valid = 1'b1; m_pend = '0; m_mask = '1; m_ipu = 1'b0; m_err = 1'b0;
      m_waiting = 1'b0; m_serving = 1'b0; m_id = 0; m_wait = 0;
      m_irq_prev = irq_v;
      return;
    end
    edges = irq_v & ~m_irq_prev;
    m_irq_prev = irq_v;
    claim = -1;
    n_ipu = 1'b0;
    if (!(m_ipu || m_waiting || m_serving)) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (m_pend[i] && !m_mask[i]) claim = i;
      if (claim >= 0) begin
        m_id = claim;
        n_ipu = 1'b1;
      end
    end else if (m_ipu) begin
      m_waiting = 1'b1;
      m_wait = 0;
    end else if (m_waiting) begin
      if (ack) begin
        m_waiting = 1'b0;
        m_serving = 1'b1;
      end else if (m_wait + 1 == ACK_TIMEOUT) begin
        m_waiting = 1'b0;
        m_err = 1'b1;
        n_ipu = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (m_serving && done_v) begin
      m_serving = 1'b0;
    end
    m_ipu = n_ipu;
    if (claim >= 0) m_pend[claim] = 1'b0;
    m_pend |= edges;
    if (mask_wr_v) m_mask = mask_in_v;
  endtask

  task automatic tick();
    rst      = rst_v;
    irq      = irq_v;
    mask_wr  = mask_wr_v;
    mask_in  = mask_in_v;
    int_done = done_v;
    int_ack  = ack_en && last_ipu;
    @(negedge clk);
    if (m_valid) begin
      chk("ipu_int",    32'(ipu_int),    32'(m_ipu));
      chk("int_id",     32'(int_id),     32'(m_id));
      chk("int_active", 32'(int_active), 32'(m_ipu | m_waiting | m_serving));
      chk("pending",    32'(pending),    32'(m_pend));
      chk("mask",       32'(mask),       32'(m_mask));
      chk("ack_err",    32'(ack_err),    32'(m_err));
    end
    model_step(int_ack);
    @(posedge clk);
    #1;
  endtask

  // From REQ: ack arrives, enter SERVICE, return via int_done.
  task automatic finish_service();
    tick();
    tick();
    done_v = 1'b1;
    tick();
    done_v = 1'b0;
  endtask

  initial begin
    int b;
    m_valid = 1'b0; last_ipu = 1'b0;
    rst_v = 1'b1; irq_v = 4'b0001; mask_wr_v = 1'b0; mask_in_v = '0;
    done_v = 1'b0; ack_en = 1'b1;
    rst = 1'b1; irq = irq_v; mask_wr = 1'b0; mask_in = '0; int_ack = 1'b0; int_done = 1'b0;
    @(posedge clk);
    #1;

    // Reset with irq[0] held high, then unmask: no edge, no request.
    tick(); tick();
    rst_v = 1'b0;
    chk("rst_mask", 32'(mask), 32'hF);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_active", 32'(int_active), 32'h0);
    mask_wr_v = 1'b1; mask_in_v = '0; tick(); mask_wr_v = 1'b0;
    tick(); tick(); tick();
    chk("held_irq_pending", 32'(pending), 32'h0);
    chk("held_irq_active", 32'(int_active), 32'h0);

    // Single source: edge -> pending -> pulse -> ack -> service -> done.
    irq_v = 4'b0101; tick();
    chk("s2_pending", 32'(pending), 32'h4);
    chk("s2_no_pulse_yet", 32'(ipu_int), 32'h0);
    tick();
    chk("s2_pulse", 32'(ipu_int), 32'h1);
    chk("s2_id", 32'(int_id), 32'h2);
    chk("s2_cleared", 32'(pending), 32'h0);
    tick();
    chk("s2_pulse_one_cycle", 32'(ipu_int), 32'h0);
    tick(); tick(); tick();
    chk("s2_in_service", 32'(int_active), 32'h1);
    done_v = 1'b1; tick(); done_v = 1'b0;
    chk("s2_idle", 32'(int_active), 32'h0);
    chk("s2_id_held", 32'(int_id), 32'h2);

    // Simultaneous edges on 3 and 1: lower index first.
    irq_v = 4'b1111; tick();
    chk("s3_pending", 32'(pending), 32'hA);
    tick();
    chk("s3_first_id", 32'(int_id), 32'h1);
    finish_service();
    chk("s3_gap", 32'(ipu_int), 32'h0);
    tick();
    chk("s3_second_pulse", 32'(ipu_int), 32'h1);
    chk("s3_second_id", 32'(int_id), 32'h3);
    finish_service();

    // Masked edge stays pending; unmask yields request two cycles after write.
    mask_wr_v = 1'b1; mask_in_v = 4'b0100; tick(); mask_wr_v = 1'b0;
    irq_v = 4'b1011; tick();
    irq_v = 4'b1111; tick();
    tick();
    chk("s4_masked_pending", 32'(pending), 32'h4);
    chk("s4_no_request", 32'(int_active), 32'h0);
    mask_wr_v = 1'b1; mask_in_v = 4'b0000; tick(); mask_wr_v = 1'b0;
    chk("s4_not_yet", 32'(ipu_int), 32'h0);
    tick();
    chk("s4_pulse", 32'(ipu_int), 32'h1);
    chk("s4_id", 32'(int_id), 32'h2);
    finish_service();

    // Ack timeout: re-pulse with same ID, sticky error.
    ack_en = 1'b0;
    irq_v = 4'b1110; tick();
    irq_v = 4'b1111; tick();
    tick();
    chk("s5_pulse", 32'(ipu_int), 32'h1);
    tick(); tick(); tick(); tick();
    chk("s5_still_waiting", 32'(ipu_int), 32'h0);
    chk("s5_no_err_yet", 32'(ack_err), 32'h0);
    tick();
    chk("s5_repulse", 32'(ipu_int), 32'h1);
    chk("s5_err", 32'(ack_err), 32'h1);
    chk("s5_same_id", 32'(int_id), 32'h0);
    ack_en = 1'b1;
    finish_service();
    chk("s5_err_sticky", 32'(ack_err), 32'h1);

    // Re-edge in the claim cycle keeps pending set; then reset in SERVICE.
    mask_wr_v = 1'b1; mask_in_v = 4'b0001; tick(); mask_wr_v = 1'b0;
    irq_v = 4'b1110; tick();
    irq_v = 4'b1111; tick();
    irq_v = 4'b1110; tick();
    chk("s6_masked_pending", 32'(pending), 32'h1);
    mask_wr_v = 1'b1; mask_in_v = 4'b0000; tick(); mask_wr_v = 1'b0;
    irq_v = 4'b1111; tick();
    chk("s6_claim", 32'(ipu_int), 32'h1);
    chk("s6_reedge_kept", 32'(pending), 32'h1);
    finish_service();
    tick();
    chk("s6_reserviced", 32'(ipu_int), 32'h1);
    chk("s6_reserviced_id", 32'(int_id), 32'h0);
    tick(); tick();
    chk("s6_service", 32'(int_active), 32'h1);
    rst_v = 1'b1; tick(); rst_v = 1'b0;
    chk("s6_rst_active", 32'(int_active), 32'h0);
    chk("s6_rst_ipu", 32'(ipu_int), 32'h0);
    chk("s6_rst_err", 32'(ack_err), 32'h0);
    chk("s6_rst_mask", 32'(mask), 32'hF);
    chk("s6_rst_pending", 32'(pending), 32'h0);
    chk("s6_rst_id", 32'(int_id), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, NSRC - 1);
        irq_v[b] = ~irq_v[b];
      end
      mask_wr_v = ($urandom_range(0, 15) == 0);
      mask_in_v = NSRC'($urandom & $urandom);
      if ($urandom_range(0, 39) == 0) ack_en = ~ack_en;
      done_v = ($urandom_range(0, 3) == 0);
      rst_v  = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_v = 1'b0; mask_wr_v = 1'b0; done_v = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller on the requesting side of the fetch stage's interrupt handshake.
- Edge-detects and latches up to 2**ID_W external interrupt lines, applies a mask and fixed priority, and drives a one-cycle ipu_int pulse into fetch.
- Waits for fetch's registered int_ack, holds the claimed source ID for the handler, and treats the handler as in service until fetch signals return-from-interrupt (int_done).
- No nesting: one interrupt in service at a time.

Parameters:
- ID_W, 2, width of the source ID; number of sources NSRC = 2**ID_W.
- ACK_TIMEOUT, 4, cycles to wait in ACK for int_ack before re-issuing the request; range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- irq  input  NSRC  external interrupt lines, rising-edge sensitive.
- mask_wr  input  1  load mask register this cycle.
- mask_in  input  NSRC  new mask value; 1 = source masked.
- int_ack  input  1  from fetch; registered copy of ipu_int.
- int_done  input  1  from fetch; return-from-interrupt opcode (0011) currently fetched.
- ipu_int  output  1  interrupt request to fetch; one-cycle pulse.
- int_id  output  ID_W  ID of the claimed source; stable from REQ until IDLE.
- int_active  output  1  high in REQ, ACK and SERVICE.
- pending  output  NSRC  latched, unserviced edges (masked sources included).
- mask  output  NSRC  current mask register.
- ack_err  output  1  sticky; set on any ACK timeout.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; ipu_int=0; int_id=0; int_active=0; pending=0; mask=all ones; ack_err=0; timeout counter=0.
  - irq_q <= irq during reset, so a line already high through reset produces no edge.
  - Reset mid-operation, including during SERVICE, abandons the interrupt with no further pulses.
- Edge detect: edge = irq & ~irq_q; irq_q <= irq every cycle.
- Pending: pending <= (pending & ~clear) | edge.
  - clear is one-hot of the claimed ID in the claiming cycle, else 0.
  - Set wins: an edge on the same source in the claim cycle leaves the bit set.
- Mask: on mask_wr, mask <= mask_in, effective for eligibility the next cycle. Masking never clears pending bits.
- Eligibility: elig = pending & ~mask. The winner is the lowest set index (index 0 is highest priority).
- State machine (registered state; ipu_int is a registered output):
  - IDLE: if elig != 0, go to REQ. Latch int_id = winner and clear that pending bit in the same edge.
  - REQ: ipu_int=1 for exactly this one cycle. Go to ACK; counter=0.
  - ACK:
    - int_ack=1: go to SERVICE.
    - Otherwise counter+1. When counter reaches ACK_TIMEOUT-1 without ack: set ack_err and return to REQ, re-issuing the same int_id with no re-claim.
  - SERVICE: wait for int_done=1, then go to IDLE. int_done is ignored in every other state.
  - From IDLE, a new REQ occurs no earlier than the cycle after entering IDLE, giving a minimum 1-cycle gap between handler exit and the next ipu_int.
- Latency: irq rising edge at cycle N → pending bit visible N+1 → IDLE claims at N+1 → ipu_int high during N+2 → int_ack expected high during N+3.
- Edges arriving while not in IDLE accumulate in pending and are arbitrated on the next IDLE.
- int_active = (state != IDLE). int_id holds its value in IDLE until the next claim.

Test Plan:
- Reset with irq=4'b0001 held high, then mask_wr with mask_in=0 → no ipu_int; pending=0.
- mask=0; irq[2] rises at cycle 10 → pending[2]=1 at cycle 11; ipu_int=1 only in cycle 12; int_id=2; pending[2] cleared. Fetch model returns int_ack in cycle 13 → SERVICE. int_done at cycle 20 → IDLE at 21, int_active=0.
- irq[3] and irq[1] rise in the same cycle → first claim int_id=1. After int_done, second claim int_id=3, with ipu_int pulses at least 2 cycles apart.
- mask=4'b0100, irq[2] edge → pending[2]=1 with no request. Write mask=0 → ipu_int two cycles after the write.
- Hold int_ack=0 with ACK_TIMEOUT=4 → ack_err=1 and ipu_int re-pulses with the same int_id. Next int_ack → SERVICE; ack_err stays 1 until reset.
- irq[0] re-edges in its own claim cycle → pending[0] stays 1 and is serviced again after int_done. Assert rst during SERVICE → all outputs return to reset values the next cycle.
